// File: rtl/dvsd_seqmul.sv
// Iterative shift-add multiplier: one partial-product add per clock, valid/ready on both sides.
// Define DVSD_SEQMUL_SIGNED_EN to add the signed_mode port for two's-complement operands.
module dvsd_seqmul #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] m,
    output logic               busy
`ifdef DVSD_SEQMUL_SIGNED_EN
    ,
    input  logic               signed_mode
`endif
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    mcand, acc, acc_sum, prod;
    logic [WIDTH-1:0] mplr, a_mag, b_mag;
    logic [CW-1:0]    cnt;
    logic             neg, neg_in, last;

`ifdef DVSD_SEQMUL_SIGNED_EN
    // Operands are loaded as magnitudes; the sign is reapplied when m is loaded.
    // -2^(WIDTH-1) negates to 2^(WIDTH-1), which is exact as an unsigned magnitude.
    logic sa, sb;
    assign sa     = signed_mode & a[WIDTH-1];
    assign sb     = signed_mode & b[WIDTH-1];
    assign a_mag  = sa ? (~a + WIDTH'(1)) : a;
    assign b_mag  = sb ? (~b + WIDTH'(1)) : b;
    assign neg_in = sa ^ sb;
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign neg_in = 1'b0;
`endif

    assign acc_sum = acc + (mplr[0] ? mcand : '0);
    assign prod    = neg ? (~acc_sum + PW'(1)) : acc_sum;
    assign last    = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = rst_n;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            m     <= '0;
        end else if (state == IDLE && in_valid) begin
            mcand <= {{WIDTH{1'b0}}, a_mag};
            mplr  <= b_mag;
            acc   <= '0;
            cnt   <= '0;
            neg   <= neg_in;
        end else if (state == RUN) begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + CW'(1);
            if (last) m <= prod;
        end
    end

endmodule

// File: tb/tb_dvsd_seqmul.sv
// Self-checking bench for dvsd_seqmul: an 8-bit and a 16-bit instance, table vectors,
// hand-written handshake/reset sequences and a scoreboard per instance.
module tb_dvsd_seqmul;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, ov8, or8 = 0, busy8, sm8 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] m8;
    logic        iv16 = 0, ir16, ov16, or16 = 1, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] m16;

    int n_cmp = 0, n_fail = 0, cyc = 0;
    logic [15:0] q8[$];
    logic [31:0] q16[$];

    dvsd_seqmul #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .out_valid(ov8), .out_ready(or8), .m(m8), .busy(busy8)
`ifdef DVSD_SEQMUL_SIGNED_EN
        , .signed_mode(sm8)
`endif
    );

    dvsd_seqmul #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .out_valid(ov16), .out_ready(or16), .m(m16), .busy(busy16)
`ifdef DVSD_SEQMUL_SIGNED_EN
        , .signed_mode(1'b0)
`endif
    );

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboards: pop on every output handshake.
    always @(negedge clk) begin
        if (rst_n && ov8 && or8) begin
            if (q8.size() == 0) chk("sb8_unexpected", 1, 0);
            else chk("sb8_m", m8, q8.pop_front());
        end
        if (rst_n && ov16 && or16) begin
            if (q16.size() == 0) chk("sb16_unexpected", 1, 0);
            else chk("sb16_m", m16, q16.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic sm, output int t);
        int w = 0;
        while (!ir8 && w < 50) begin step(); w++; end
        if (!ir8) chk("issue8_timeout", 0, 1);
        a8 = x; b8 = y; sm8 = sm; iv8 = 1;
        step();
        t = cyc;
        iv8 = 0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    endtask

    task automatic wait_ov8(output int lat);
        lat = 0;
        while (!ov8 && lat < 40) begin step(); lat++; end
        if (!ov8) chk("ov8_timeout", 0, 1);
    endtask

    task automatic run8(input string nm, input logic [7:0] x, input logic [7:0] y,
                        input logic sm, input int hold, input logic [15:0] exp);
        int t, lat;
        q8.push_back(exp);
        issue8(x, y, sm, t);
        wait_ov8(lat);
        chk({nm, "_latency"}, lat, 8);
        for (int i = 0; i < hold; i++) begin
            chk({nm, "_hold_m"}, m8, exp);
            chk({nm, "_hold_valid"}, ov8, 1);
            chk({nm, "_hold_in_ready"}, ir8, 0);
            iv8 = 1;
            step();
        end
        iv8 = 0; or8 = 1;
        step();
        or8 = 0;
        chk({nm, "_valid_drop"}, ov8, 0);
        chk({nm, "_in_ready_back"}, ir8, 1);
        chk({nm, "_m_kept"}, m8, exp);
    endtask

    task automatic run16(input string nm, input logic [15:0] x, input logic [15:0] y,
                         input logic [31:0] exp);
        int w = 0, lat = 0;
        q16.push_back(exp);
        while (!ir16 && w < 50) begin step(); w++; end
        if (!ir16) chk({nm, "_issue_timeout"}, 0, 1);
        a16 = x; b16 = y; iv16 = 1;
        step();
        iv16 = 0; a16 = 16'($urandom);
        while (!ov16 && lat < 60) begin step(); lat++; end
        chk({nm, "_latency"}, lat, 16);
        step();
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          hold;
        logic [15:0] m;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[6];
        int t1, t2, lat;
        tbl[0] = '{8'h00, 8'hFF, 0, 16'h0000};
        tbl[1] = '{8'hFF, 8'hFF, 0, 16'hFE01};
        tbl[2] = '{8'h0D, 8'h0B, 5, 16'h008F};
        tbl[3] = '{8'h01, 8'h01, 1, 16'h0001};
        tbl[4] = '{8'h80, 8'h02, 2, 16'h0100};
        tbl[5] = '{8'hFF, 8'h01, 0, 16'h00FF};

        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_m", m8, 0);
        chk("rst_busy", busy8, 0);
        chk("rst_in_ready", ir8, 0);
        chk("rst_m16", m16, 0);
        step(); step();
        rst_n = 1;
        step();

        for (int i = 0; i < 6; i++) run8($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, 1'b0, tbl[i].hold, tbl[i].m);

        // Back-to-back issue with out_ready high: 10-cycle interval.
        or8 = 1;
        q8.push_back(16'hFE01);
        issue8(8'hFF, 8'hFF, 1'b0, t1);
        wait_ov8(lat);
        q8.push_back(16'hFE01);
        issue8(8'hFF, 8'hFF, 1'b0, t2);
        chk("issue_interval", t2 - t1, 10);
        wait_ov8(lat);
        chk("interval_latency", lat, 8);
        step();
        or8 = 0;

        // Reset mid-RUN discards the operation.
        issue8(8'hAA, 8'h55, 1'b0, t1);
        step(); step();
        chk("midrun_busy", busy8, 1);
        rst_n = 0;
        #1;
        chk("midrst_out_valid", ov8, 0);
        chk("midrst_m", m8, 0);
        chk("midrst_busy", busy8, 0);
        chk("midrst_in_ready", ir8, 0);
        step();
        rst_n = 1;
        step();
        run8("post_rst", 8'h03, 8'h04, 1'b0, 0, 16'h000C);

        for (int i = 0; i < 20; i++) begin
            logic [7:0] x, y;
            x = 8'($urandom); y = 8'($urandom);
            run8("rand8", x, y, 1'b0, i % 3, 16'(x) * 16'(y));
        end

`ifdef DVSD_SEQMUL_SIGNED_EN
        run8("s_ff_ff", 8'hFF, 8'hFF, 1'b1, 0, 16'h0001);
        run8("s_80_7f", 8'h80, 8'h7F, 1'b1, 1, 16'hC080);
        run8("s_80_80", 8'h80, 8'h80, 1'b1, 0, 16'h4000);
        run8("u_80_80", 8'h80, 8'h80, 1'b0, 0, 16'h4000);
        run8("s_7f_ff", 8'h7F, 8'hFF, 1'b1, 0, 16'hFF81);
        for (int i = 0; i < 20; i++) begin
            logic [7:0] x, y;
            logic signed [15:0] p;
            x = 8'($urandom); y = 8'($urandom);
            p = $signed(x) * $signed(y);
            run8("srand8", x, y, 1'b1, 0, p);
        end
`endif

        run16("w16_max", 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        for (int i = 0; i < 100; i++) begin
            logic [15:0] x, y;
            x = 16'($urandom); y = 16'($urandom);
            run16("rand16", x, y, 32'(x) * 32'(y));
        end

        step(); step();
        chk("sb8_drained", q8.size(), 0);
        chk("sb16_drained", q16.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dvsd_seqmul.md
Name: dvsd_seqmul

Overview:
- Parametrised iterative shift-add multiplier; next generation of the fixed 8x8 combinational dvsd multiplier.
- Operand width is configurable. Inputs and outputs use a valid/ready handshake.
- Trades area for latency: one partial-product add per clock.
- Sits between operand producers and downstream consumers in datapath test harnesses and the accelerator core.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2..32). Product width is 2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product m valid
- out_ready  input  1  consumer accepts m
- m  output  2*WIDTH  product
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n=0:
  - state=IDLE, out_valid=0, m=0, busy=0.
  - Accumulator, shift registers and counter all cleared.
  - in_ready=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture a into a multiplicand register zero-extended to 2*WIDTH, capture b into a multiplier shift register, clear acc and cnt, then go to RUN.
  - a/b values outside the accepting edge are don't-care.
- RUN:
  - in_ready=0.
  - Each edge: if mplr[0]=1, acc <= acc + mcand. Then mcand <= mcand<<1, mplr <= mplr>>1, cnt <= cnt+1.
  - cnt is clog2(WIDTH) bits wide.
  - On the edge where cnt==WIDTH-1, perform the final add, load m <= final acc value, and go to DONE.
  - No early termination: RUN always takes exactly WIDTH edges.
- DONE:
  - out_valid=1 and m is held stable.
  - On an edge with out_ready=1, clear out_valid and go to IDLE.
  - m keeps its last value after out_valid falls.
- Latency: operands accepted on edge N; out_valid first high in the cycle after edge N+WIDTH.
- Throughput: at most one product every WIDTH+2 cycles (accept, WIDTH RUN edges, at least one DONE cycle). in_ready is 0 in DONE, so there is no overlap.
- Arithmetic: unsigned by default. The accumulator is 2*WIDTH bits and cannot overflow. The product is exact for all inputs.
- Backpressure: out_ready may stay low indefinitely. m and out_valid must not change while out_valid=1 and out_ready=0.
- Simultaneous events:
  - in_valid while busy is ignored; the operands are not queued.
  - out_ready while not in DONE has no effect.
- Reset mid-operation: rst_n low in any state aborts immediately. The result is discarded, the block returns to IDLE, and the reset values above apply.

Optional Feature:
- Macro DVSD_SEQMUL_SIGNED_EN.
- When defined:
  - Adds port signed_mode (input, 1), sampled on the accepting edge.
  - If signed_mode=1, a and b are two's complement. Their magnitudes are loaded, the product is negated on the edge that loads m when sign(a)^sign(b)=1, and m is a 2*WIDTH two's-complement result.
  - The most-negative operand (-2^(WIDTH-1)) must be handled correctly.
  - Latency is unchanged.
- When undefined: no signed_mode port and unsigned-only operation.

Test Plan:
- WIDTH=8, a=0x00, b=0xFF -> m=0x0000; out_valid rises exactly 8 cycles after the accept edge.
- WIDTH=8, a=0xFF, b=0xFF with out_ready=1 -> m=0xFE01. After the DONE cycle, in_ready returns to 1, giving a 10-cycle issue interval.
- WIDTH=8, a=0x0D, b=0x0B, out_ready held low for 5 cycles -> m=0x008F and out_valid=1 stable for all 5 cycles. A new in_valid during that window is ignored (in_ready=0).
- rst_n pulsed low for 1 cycle at the 3rd RUN cycle of 0xAA*0x55 -> out_valid=0, m=0 and busy=0 immediately. A following 0x03*0x04 gives m=0x000C.
- WIDTH=16, a=0xFFFF, b=0xFFFF -> m=0xFFFE0001 after 16 cycles. Run 100 random pairs checked against a reference model.
- DVSD_SEQMUL_SIGNED_EN, WIDTH=8, signed_mode=1:
  - 0xFF*0xFF -> m=0x0001.
  - 0x80*0x7F -> m=0xC080.
  - 0x80*0x80 -> m=0x4000.
  - signed_mode=0 with 0x80*0x80 -> m=0x4000.
